// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : icache_pkg
//  Description : Shared definitions for the N-way instruction cache line
//                engine: FSM state encoding, replacement-mode constants and
//                address-field width helpers.
//  Revision    : 1.0  initial release
// ============================================================================
package icache_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REFILL  = 2'd1,
    ST_RESPOND = 2'd2,
    ST_FLUSH   = 2'd3
  } state_t;

  localparam int REPL_RR   = 0;
  localparam int REPL_PLRU = 1;

  // ceil(log2(n)); returns 0 for n <= 1
  function automatic int log2c(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

  function automatic int word_bits(input int line_words);
    return log2c(line_words);
  endfunction

  function automatic int set_bits(input int num_sets);
    return log2c(num_sets);
  endfunction

  function automatic int tag_bits(input int addr_width, input int line_words, input int num_sets);
    return addr_width - 2 - word_bits(line_words) - set_bits(num_sets);
  endfunction

  // Way index width; a direct-mapped cache still carries a 1-bit way index.
  function automatic int way_bits(input int assoc);
    return (assoc > 1) ? log2c(assoc) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/icache_plru.sv
`default_nettype none
// ============================================================================
//  Module      : icache_plru
//  Description : Per-set tree pseudo-LRU state. Provides the victim way for
//                a lookup set and updates a set's tree to point away from a
//                touched way. One tree bit per internal node, heap ordered
//                (node n has children 2n+1 / 2n+2); a 0 bit steers the
//                victim search to the lower half, 1 to the upper half.
//  Ports       : clk, rst_n      clock, async active-low reset
//                rd_set/victim   lookup set -> policy victim way
//                upd_en/upd_set/upd_way  touch a way (hit or fill)
//                clr_en/clr_set  clear one set's tree (flush)
//  Revision    : 1.0  initial release
// ============================================================================
module icache_plru
  import icache_pkg::*;
#(
  parameter int NUM_SETS      = 64,
  parameter int ASSOCIATIVITY = 2,
  parameter int SET_W         = 6,
  parameter int WAY_W         = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SET_W-1:0] rd_set,
  output logic [WAY_W-1:0] victim,
  input  logic             upd_en,
  input  logic [SET_W-1:0] upd_set,
  input  logic [WAY_W-1:0] upd_way,
  input  logic             clr_en,
  input  logic [SET_W-1:0] clr_set
);

  localparam int LEVELS = log2c(ASSOCIATIVITY);
  localparam int NODES  = (ASSOCIATIVITY > 1) ? ASSOCIATIVITY - 1 : 1;

  logic [NODES-1:0] tree [NUM_SETS];
  logic [NODES-1:0] rd_bits;
  logic [NODES-1:0] upd_bits;
  int               rd_node;
  int               upd_node;
  logic             upd_dir;

  // Walk root to leaf following the stored direction bits.
  always_comb begin
    rd_bits = tree[rd_set];
    rd_node = 0;
    victim  = '0;
    for (int l = 0; l < LEVELS; l++) begin
      victim  = (victim << 1) | WAY_W'(rd_bits[rd_node]);
      rd_node = 2 * rd_node + 1 + int'(rd_bits[rd_node]);
    end
  end

  // Along the touched way's path, point every node at the other half.
  always_comb begin
    upd_bits = tree[upd_set];
    upd_node = 0;
    upd_dir  = 1'b0;
    for (int l = 0; l < LEVELS; l++) begin
      upd_dir            = upd_way[LEVELS-1-l];
      upd_bits[upd_node] = ~upd_dir;
      upd_node           = 2 * upd_node + 1 + int'(upd_dir);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) tree[s] <= '0;
    end else if (clr_en) begin
      tree[clr_set] <= '0;
    end else if (upd_en) begin
      tree[upd_set] <= upd_bits;
    end
  end

endmodule
`default_nettype wire

// File: rtl/icache_line_nway.sv
`default_nettype none
// ============================================================================
//  Module      : icache_line_nway
//  Description : Set-associative instruction cache with line refill over a
//                beat-wise memory port, round-robin or tree-PLRU victim
//                selection and a sequential invalidate-all flush.
//  Ports       : clk, rst_n                    clock, async active-low reset
//                cpu_req/cpu_addr              fetch request, byte address
//                cpu_data/cpu_valid/cpu_stall  fetched word, pulse, stall
//                flush_req/flush_busy          invalidate-all pulse, busy
//                mem_req/mem_addr              burst request, line base
//                mem_data/mem_valid            refill beat data, strobe
//                cache_hit/miss/evict          statistics pulses
//  Revision    : 1.0  initial release
// ============================================================================
module icache_line_nway
  import icache_pkg::*;
#(
  parameter int ADDR_WIDTH    = 32,
  parameter int DATA_WIDTH    = 32,
  parameter int NUM_SETS      = 64,
  parameter int ASSOCIATIVITY = 2,
  parameter int LINE_WORDS    = 4,
  parameter int REPL_MODE     = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  cpu_req,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  output logic [DATA_WIDTH-1:0] cpu_data,
  output logic                  cpu_valid,
  output logic                  cpu_stall,
  input  logic                  flush_req,
  output logic                  flush_busy,
  output logic                  mem_req,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  input  logic                  mem_valid,
  output logic                  cache_hit,
  output logic                  cache_miss,
  output logic                  cache_evict
);

  localparam int WORD_W = word_bits(LINE_WORDS);
  localparam int WIDX_W = (WORD_W > 0) ? WORD_W : 1;
  localparam int SET_W  = set_bits(NUM_SETS);
  localparam int TAG_W  = tag_bits(ADDR_WIDTH, LINE_WORDS, NUM_SETS);
  localparam int WAY_W  = way_bits(ASSOCIATIVITY);
  localparam int LOW_W  = WORD_W + 2;

  // ---------------- storage ----------------
  logic [DATA_WIDTH-1:0]    data_mem [ASSOCIATIVITY][NUM_SETS][LINE_WORDS];
  logic [TAG_W-1:0]         tag_mem  [ASSOCIATIVITY][NUM_SETS];
  logic [ASSOCIATIVITY-1:0] valid    [NUM_SETS];

  // ---------------- request decode ----------------
  logic [TAG_W-1:0]  req_tag;
  logic [SET_W-1:0]  req_set;
  logic [WIDX_W-1:0] req_word;
  logic              unused_addr_bits;

  assign req_tag          = cpu_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_set          = cpu_addr[LOW_W +: SET_W];
  assign unused_addr_bits = ^cpu_addr[1:0];

  generate
    if (WORD_W > 0) begin : g_word_idx
      assign req_word = cpu_addr[2 +: WORD_W];
    end else begin : g_word_single
      assign req_word = '0;
    end
  endgenerate

  // ---------------- state ----------------
  state_t            state;
  state_t            state_next;
  logic [TAG_W-1:0]  cur_tag;
  logic [SET_W-1:0]  cur_set;
  logic [WIDX_W-1:0] cur_word;
  logic [WAY_W-1:0]  cur_way;
  logic              cur_victim_valid;
  logic [WIDX_W-1:0] beat_cnt;
  logic [DATA_WIDTH-1:0] word_buf;
  logic              pending;
  logic [SET_W-1:0]  flush_set;

  // ---------------- lookup ----------------
  logic             hit;
  logic [WAY_W-1:0] hit_way;
  logic             any_free;
  logic [WAY_W-1:0] free_way;
  logic [WAY_W-1:0] policy_way;
  logic [WAY_W-1:0] victim;

  // Descending loops leave the lowest matching index in the result.
  always_comb begin
    hit      = 1'b0;
    hit_way  = '0;
    any_free = 1'b0;
    free_way = '0;
    for (int w = ASSOCIATIVITY - 1; w >= 0; w--) begin
      if (valid[req_set][w] && (tag_mem[w][req_set] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid[req_set][w]) begin
        any_free = 1'b1;
        free_way = WAY_W'(w);
      end
    end
  end

  assign victim = any_free ? free_way : policy_way;

  // ---------------- control ----------------
  logic flush_go;
  logic idle;
  logic hit_take;
  logic miss_take;
  logic beat_take;
  logic last_beat;
  logic fill_done;
  logic in_flush;
  logic flush_last;
  logic stall_c;
  logic mem_req_c;

  assign flush_go   = pending | flush_req;
  assign idle       = (state == ST_IDLE);
  assign hit_take   = idle & ~flush_go & cpu_req & hit;
  assign miss_take  = idle & ~flush_go & cpu_req & ~hit;
  assign beat_take  = (state == ST_REFILL) & mem_valid;
  assign last_beat  = (beat_cnt == WIDX_W'(LINE_WORDS - 1));
  assign fill_done  = beat_take & last_beat;
  assign in_flush   = (state == ST_FLUSH);
  assign flush_last = (flush_set == SET_W'(NUM_SETS - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    stall_c    = 1'b0;
    mem_req_c  = 1'b0;
    case (state)
      ST_IDLE: begin
        // A pending flush wins over a fetch in the same cycle.
        stall_c = flush_go | (cpu_req & ~hit);
        if (flush_go)            state_next = ST_FLUSH;
        else if (cpu_req && !hit) state_next = ST_REFILL;
      end
      ST_REFILL: begin
        stall_c   = 1'b1;
        mem_req_c = 1'b1;
        if (fill_done) state_next = ST_RESPOND;
      end
      ST_RESPOND: begin
        stall_c    = 1'b1;
        state_next = ST_IDLE;
      end
      ST_FLUSH: begin
        stall_c = 1'b1;
        if (flush_last) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Combinational outputs are held low while reset is asserted.
  assign cpu_stall  = rst_n & stall_c;
  assign mem_req    = rst_n & mem_req_c;
  assign mem_addr   = mem_req ? {cur_tag, cur_set, LOW_W'(0)} : '0;
  assign flush_busy = rst_n & (flush_req | pending | in_flush);

  // ---------------- datapath registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cpu_data         <= '0;
      cpu_valid        <= 1'b0;
      cache_hit        <= 1'b0;
      cache_miss       <= 1'b0;
      cache_evict      <= 1'b0;
      cur_tag          <= '0;
      cur_set          <= '0;
      cur_word         <= '0;
      cur_way          <= '0;
      cur_victim_valid <= 1'b0;
      beat_cnt         <= '0;
      word_buf         <= '0;
      pending          <= 1'b0;
      flush_set        <= '0;
    end else begin
      cpu_valid   <= 1'b0;
      cache_hit   <= 1'b0;
      cache_miss  <= 1'b0;
      cache_evict <= 1'b0;

      if (hit_take) begin
        cpu_valid <= 1'b1;
        cache_hit <= 1'b1;
        cpu_data  <= data_mem[hit_way][req_set][req_word];
      end

      if (miss_take) begin
        cur_tag          <= req_tag;
        cur_set          <= req_set;
        cur_word         <= req_word;
        cur_way          <= victim;
        cur_victim_valid <= valid[req_set][victim];
        beat_cnt         <= '0;
      end

      if (beat_take) begin
        if (beat_cnt == cur_word) word_buf <= mem_data;
        beat_cnt <= last_beat ? '0 : beat_cnt + WIDX_W'(1);
        if (last_beat) begin
          // The requested word may be this very beat, so bypass the buffer.
          cpu_valid   <= 1'b1;
          cache_miss  <= 1'b1;
          cache_evict <= cur_victim_valid;
          cpu_data    <= (beat_cnt == cur_word) ? mem_data : word_buf;
        end
      end

      if (idle && flush_go) pending <= 1'b0;
      else if (flush_req)   pending <= 1'b1;

      if (idle && flush_go) flush_set <= '0;
      else if (in_flush)    flush_set <= flush_set + SET_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < NUM_SETS; s++) valid[s] <= '0;
    end else if (in_flush) begin
      valid[flush_set] <= '0;
    end else if (fill_done) begin
      valid[cur_set][cur_way] <= 1'b1;
    end
  end

  // Line contents carry no reset; the valid bits gate visibility.
  always_ff @(posedge clk) begin
    if (beat_take) begin
      data_mem[cur_way][cur_set][beat_cnt] <= mem_data;
      if (last_beat) tag_mem[cur_way][cur_set] <= cur_tag;
    end
  end

  // ---------------- replacement policy ----------------
  generate
    if (ASSOCIATIVITY == 1) begin : g_repl_direct
      assign policy_way = '0;
    end else if (REPL_MODE == REPL_PLRU) begin : g_repl_plru
      icache_plru #(
        .NUM_SETS      (NUM_SETS),
        .ASSOCIATIVITY (ASSOCIATIVITY),
        .SET_W         (SET_W),
        .WAY_W         (WAY_W)
      ) u_plru (
        .clk     (clk),
        .rst_n   (rst_n),
        .rd_set  (req_set),
        .victim  (policy_way),
        .upd_en  (hit_take | fill_done),
        .upd_set (hit_take ? req_set : cur_set),
        .upd_way (hit_take ? hit_way : cur_way),
        .clr_en  (in_flush),
        .clr_set (flush_set)
      );
    end else begin : g_repl_rr
      logic [WAY_W-1:0] rr_ptr [NUM_SETS];

      // Pointer moves on fills only; power-of-two ways wrap naturally.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int s = 0; s < NUM_SETS; s++) rr_ptr[s] <= '0;
        end else if (in_flush) begin
          rr_ptr[flush_set] <= '0;
        end else if (fill_done) begin
          rr_ptr[cur_set] <= rr_ptr[cur_set] + WAY_W'(1);
        end
      end

      assign policy_way = rr_ptr[req_set];
    end
  endgenerate

endmodule
`default_nettype wire
